// File: rtl/complex_row_bank.sv
// Row-addressed SIZE x SIZE complex matrix store: loads rows, launches the engine,
// serves its row reads and write-backs, then drains the updated matrix in order.
module complex_row_bank #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [SIZE*2*WIDTH-1:0]     load_row_i,
    input  logic                        load_valid_i,
    output logic                        load_ready_o,
    output logic                        start_o,
    input  logic [$clog2(SIZE)-1:0]     rd_addr_i,
    input  logic                        rd_addr_valid_i,
    output logic [SIZE*2*WIDTH-1:0]     rd_row_o,
    output logic [$clog2(SIZE)-1:0]     rd_addr_o,
    output logic                        rd_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]     wr_row_i,
    input  logic [$clog2(SIZE)-1:0]     wr_addr_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic                        drain_start_i,
    output logic [SIZE*2*WIDTH-1:0]     drain_row_o,
    output logic [$clog2(SIZE)-1:0]     drain_addr_o,
    output logic                        drain_valid_o,
    input  logic                        drain_ready_i,
    output logic                        busy_o
);

    localparam int AW = $clog2(SIZE);
    localparam int RW = SIZE * 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_load_cnt;
    logic [AW-1:0]   r_drain_cnt;
    logic [RW-1:0]   r_mem [SIZE];
    logic [RW-1:0]   r_rd_row;
    logic [AW-1:0]   r_rd_addr;
    logic            r_rd_valid;
    logic            r_start;
    logic            r_busy;

    logic            w_load_acc;
    logic            w_load_last;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic            w_drain_go;
    logic            w_drain_acc;
    logic            w_drain_last;

    // flush_i suppresses every state-changing action in the cycle it is seen
    assign w_load_acc   = (r_state == ST_LOAD)  & load_valid_i  & ~flush_i;
    assign w_load_last  = w_load_acc & (r_load_cnt == AW'(SIZE - 1));
    assign w_wr_acc     = (r_state == ST_SERVE) & wr_valid_i    & ~flush_i;
    assign w_rd_acc     = (r_state == ST_SERVE) & rd_addr_valid_i & ~flush_i;
    assign w_drain_go   = (r_state == ST_SERVE) & drain_start_i & ~flush_i;
    assign w_drain_acc  = (r_state == ST_DRAIN) & drain_ready_i & ~flush_i;
    assign w_drain_last = w_drain_acc & (r_drain_cnt == AW'(SIZE - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:  if (w_load_last)  w_next_state = ST_SERVE;
                ST_SERVE: if (w_drain_go)   w_next_state = ST_DRAIN;
                ST_DRAIN: if (w_drain_last) w_next_state = ST_LOAD;
                default:                    w_next_state = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_load_cnt  <= '0;
            r_drain_cnt <= '0;
        end else if (flush_i) begin
            r_load_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_load_acc) begin
                r_load_cnt <= w_load_last ? '0 : r_load_cnt + 1'b1;
            end
            if (w_drain_acc) begin
                r_drain_cnt <= w_drain_last ? '0 : r_drain_cnt + 1'b1;
            end
        end
    end

    // Load and write-back never coincide: they are qualified by different states
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_load_acc) begin
                r_mem[r_load_cnt] <= load_row_i;
            end
            if (w_wr_acc) begin
                r_mem[wr_addr_i] <= wr_row_i;
            end
        end
    end

    // Read port samples the array before this edge's write, so same-address reads see old data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_valid <= 1'b0;
            r_rd_row   <= '0;
            r_rd_addr  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_row  <= r_mem[rd_addr_i];
                r_rd_addr <= rd_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= w_load_last;
            r_busy  <= (r_state != ST_LOAD);
        end
    end

    assign load_ready_o  = (r_state == ST_LOAD);
    assign start_o       = r_start;
    assign rd_row_o      = r_rd_row;
    assign rd_addr_o     = r_rd_addr;
    assign rd_valid_o    = r_rd_valid;
    assign wr_ready_o    = (r_state == ST_SERVE);
    assign drain_row_o   = r_mem[r_drain_cnt];
    assign drain_addr_o  = r_drain_cnt;
    assign drain_valid_o = (r_state == ST_DRAIN);
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_complex_row_bank.sv
// Directed self-checking bench for complex_row_bank: load, serve, drain, flush and reset.
module tb_complex_row_bank;

    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int AW    = 2;
    localparam int RW    = SIZE * 2 * WIDTH;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic [RW-1:0]   load_row_i;
    logic            load_valid_i;
    logic            load_ready_o;
    logic            start_o;
    logic [AW-1:0]   rd_addr_i;
    logic            rd_addr_valid_i;
    logic [RW-1:0]   rd_row_o;
    logic [AW-1:0]   rd_addr_o;
    logic            rd_valid_o;
    logic [RW-1:0]   wr_row_i;
    logic [AW-1:0]   wr_addr_i;
    logic            wr_valid_i;
    logic            wr_ready_o;
    logic            drain_start_i;
    logic [RW-1:0]   drain_row_o;
    logic [AW-1:0]   drain_addr_o;
    logic            drain_valid_o;
    logic            drain_ready_i;
    logic            busy_o;

    int checks   = 0;
    int failures = 0;
    logic [RW-1:0] model [SIZE];

    always #5 clk_i = ~clk_i;

    complex_row_bank #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .load_row_i     (load_row_i),
        .load_valid_i   (load_valid_i),
        .load_ready_o   (load_ready_o),
        .start_o        (start_o),
        .rd_addr_i      (rd_addr_i),
        .rd_addr_valid_i(rd_addr_valid_i),
        .rd_row_o       (rd_row_o),
        .rd_addr_o      (rd_addr_o),
        .rd_valid_o     (rd_valid_o),
        .wr_row_i       (wr_row_i),
        .wr_addr_i      (wr_addr_i),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .drain_start_i  (drain_start_i),
        .drain_row_o    (drain_row_o),
        .drain_addr_o   (drain_addr_o),
        .drain_valid_o  (drain_valid_o),
        .drain_ready_i  (drain_ready_i),
        .busy_o         (busy_o)
    );

    function automatic logic [RW-1:0] ident(input int i);
        logic [RW-1:0] r;
        r = '0;
        r[i*2*WIDTH +: WIDTH] = 64'h3FF0000000000000;
        return r;
    endfunction

    function automatic logic [RW-1:0] fill(input logic [WIDTH-1:0] v);
        return {(2*SIZE){v}};
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_all(input int with_model_ident);
        for (int i = 0; i < SIZE; i++) begin
            model[i]     = (with_model_ident != 0) ? ident(i) : fill(64'(i + 1));
            load_row_i   = model[i];
            load_valid_i = 1'b1;
            chk("load_ready_before_accept", RW'(load_ready_o), RW'(1));
            tick();
        end
        load_valid_i = 1'b0;
    endtask

    initial begin
        logic        rdy_pat [6];
        int          exp_addr [6];
        rdy_pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_addr = '{0, 1, 1, 2, 3, 3};

        rst_ni = 1'b0; flush_i = 1'b0; load_row_i = '0; load_valid_i = 1'b0;
        rd_addr_i = '0; rd_addr_valid_i = 1'b0; wr_row_i = '0; wr_addr_i = '0;
        wr_valid_i = 1'b0; drain_start_i = 1'b0; drain_ready_i = 1'b0;
        #3;
        chk("rst_load_ready", RW'(load_ready_o), RW'(1));
        chk("rst_start", RW'(start_o), RW'(0));
        chk("rst_busy", RW'(busy_o), RW'(0));
        chk("rst_rd_valid", RW'(rd_valid_o), RW'(0));
        chk("rst_drain_valid", RW'(drain_valid_o), RW'(0));
        chk("rst_wr_ready", RW'(wr_ready_o), RW'(0));
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // identity load and start pulse
        load_all(1);
        chk("load_ready_after_4", RW'(load_ready_o), RW'(0));
        chk("start_pulse", RW'(start_o), RW'(1));
        chk("wr_ready_serve", RW'(wr_ready_o), RW'(1));
        tick();
        chk("start_single_cycle", RW'(start_o), RW'(0));
        chk("busy_serve", RW'(busy_o), RW'(1));

        // back-to-back reads 3,0,2
        rd_addr_valid_i = 1'b1; rd_addr_i = 2'd3;
        tick();
        chk("rd3_valid", RW'(rd_valid_o), RW'(1));
        chk("rd3_addr", RW'(rd_addr_o), RW'(3));
        chk("rd3_row", rd_row_o, model[3]);
        rd_addr_i = 2'd0;
        tick();
        chk("rd0_valid", RW'(rd_valid_o), RW'(1));
        chk("rd0_addr", RW'(rd_addr_o), RW'(0));
        chk("rd0_row", rd_row_o, model[0]);
        rd_addr_i = 2'd2;
        tick();
        chk("rd2_valid", RW'(rd_valid_o), RW'(1));
        chk("rd2_addr", RW'(rd_addr_o), RW'(2));
        chk("rd2_row", rd_row_o, model[2]);
        rd_addr_valid_i = 1'b0;
        tick();
        chk("rd_valid_drop", RW'(rd_valid_o), RW'(0));

        // same-cycle write and read of row 1
        wr_row_i = fill(64'h4000000000000000); wr_addr_i = 2'd1; wr_valid_i = 1'b1;
        rd_addr_i = 2'd1; rd_addr_valid_i = 1'b1;
        tick();
        wr_valid_i = 1'b0;
        chk("rw_same_old", rd_row_o, ident(1));
        model[1] = fill(64'h4000000000000000);
        tick();
        chk("rw_next_new", rd_row_o, model[1]);
        rd_addr_valid_i = 1'b0;

        // write committed alongside drain start, then stalled drain
        wr_row_i = fill(64'hC000000000000000); wr_addr_i = 2'd2; wr_valid_i = 1'b1;
        drain_start_i = 1'b1;
        tick();
        model[2] = fill(64'hC000000000000000);
        wr_valid_i = 1'b0; drain_start_i = 1'b0;
        chk("wr_ready_drain", RW'(wr_ready_o), RW'(0));
        for (int k = 0; k < 6; k++) begin
            drain_ready_i = rdy_pat[k];
            chk("drain_valid", RW'(drain_valid_o), RW'(1));
            chk("drain_addr", RW'(drain_addr_o), RW'(exp_addr[k]));
            chk("drain_row", drain_row_o, model[exp_addr[k]]);
            tick();
        end
        drain_ready_i = 1'b0;
        chk("drain_done_valid", RW'(drain_valid_o), RW'(0));
        chk("drain_done_load_ready", RW'(load_ready_o), RW'(1));
        tick(); tick();
        chk("busy_idle", RW'(busy_o), RW'(0));

        // reload, then flush during drain after row 1
        load_all(0);
        chk("reload_start", RW'(start_o), RW'(1));
        tick();
        drain_start_i = 1'b1;
        tick();
        drain_start_i = 1'b0; drain_ready_i = 1'b1;
        chk("fl_row0_addr", RW'(drain_addr_o), RW'(0));
        tick();
        chk("fl_row1_row", drain_row_o, model[1]);
        tick();
        flush_i = 1'b1; drain_ready_i = 1'b0;
        chk("fl_row2_addr", RW'(drain_addr_o), RW'(2));
        tick();
        flush_i = 1'b0;
        chk("flush_drain_valid", RW'(drain_valid_o), RW'(0));
        chk("flush_load_ready", RW'(load_ready_o), RW'(1));
        load_all(1);
        chk("flush_reload_start", RW'(start_o), RW'(1));
        tick();
        chk("flush_reload_start_end", RW'(start_o), RW'(0));

        // asynchronous reset while reading in SERVE
        rd_addr_i = 2'd2; rd_addr_valid_i = 1'b1;
        tick();
        chk("pre_rst_rd_valid", RW'(rd_valid_o), RW'(1));
        chk("pre_rst_rd_row", rd_row_o, model[2]);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_rd_valid", RW'(rd_valid_o), RW'(0));
        chk("async_rst_load_ready", RW'(load_ready_o), RW'(1));
        chk("async_rst_wr_ready", RW'(wr_ready_o), RW'(0));
        chk("async_rst_busy", RW'(busy_o), RW'(0));
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_rd_ignored", RW'(rd_valid_o), RW'(0));
        for (int i = 0; i < SIZE; i++) begin
            model[i]     = ident(i);
            load_row_i   = model[i];
            load_valid_i = 1'b1;
            tick();
            chk("partial_load_rd_ignored", RW'(rd_valid_o), RW'(0));
        end
        load_valid_i = 1'b0;
        chk("post_rst_reload_start", RW'(start_o), RW'(1));
        tick();
        chk("post_rst_rd_valid", RW'(rd_valid_o), RW'(1));
        chk("post_rst_rd_row", rd_row_o, model[2]);
        rd_addr_valid_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
